// File: rtl/ram4k_arbiter_if.sv
// Bus bundle between two requesters (A = CPU data, B = DMA/refresh), the arbiter and one ram4k.
// The master side drives the requests and answers the RAM read path.
interface ram4k_arbiter_if;
  logic        a_req, a_we, a_lock;
  logic [11:0] a_addr;
  logic [15:0] a_wdata;
  logic        a_gnt, a_rvalid;
  logic [15:0] a_rdata;

  logic        b_req, b_we, b_lock;
  logic [11:0] b_addr;
  logic [15:0] b_wdata;
  logic        b_gnt, b_rvalid;
  logic [15:0] b_rdata;

  logic        ram_load;
  logic [11:0] ram_address;
  logic [15:0] ram_data_in;
  logic [15:0] ram_data_out;

  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_load, ram_address, ram_data_in,
    output ram_data_out
  );

  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_load, ram_address, ram_data_in,
    input  ram_data_out
  );
endinterface

// File: rtl/ram4k_arbiter.sv
// Two-port arbiter in front of a single 4K x 16 RAM: per-cycle grant, locked bursts with a
// burst cap, optional A-priority with a B starvation guard, registered read return per port.
module ram4k_arbiter #(
  parameter int ARB_MODE     = 0,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  ram4k_arbiter_if.slave  bus
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            last_b_q, last_b_d;

  // index 0 = port A, index 1 = port B
  logic [1:0]       req, we, lock, gnt;
  logic [1:0][11:0] addr;
  logic [1:0][15:0] wdata;
  logic [1:0]       rvalid_q;
  logic [1:0][15:0] rdata_q;
  logic             a_wins;

  assign req   = {bus.b_req,   bus.a_req};
  assign we    = {bus.b_we,    bus.a_we};
  assign lock  = {bus.b_lock,  bus.a_lock};
  assign addr  = {bus.b_addr,  bus.a_addr};
  assign wdata = {bus.b_wdata, bus.a_wdata};

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    starve_d = starve_q;
    last_b_d = last_b_q;
    gnt      = 2'b00;
    if (ARB_MODE == 0) a_wins = last_b_q;
    else               a_wins = (starve_q < SW'(STARVE_LIMIT));

    // An owner keeps the RAM while it holds lock, until the cap is hit and the other side waits.
    if (state_q == OWN_A && req[0] && lock[0]) begin
      if (burst_q < BW'(MAX_BURST) || !req[1]) gnt = 2'b01;
      else                                     gnt = 2'b10;
    end else if (state_q == OWN_B && req[1] && lock[1]) begin
      if (burst_q < BW'(MAX_BURST) || !req[0]) gnt = 2'b10;
      else                                     gnt = 2'b01;
    end else if (req == 2'b11) begin
      gnt = a_wins ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
    if (rst_i) gnt = 2'b00;

    if (gnt[0] && lock[0]) begin
      state_d = OWN_A;
      if (state_q != OWN_A)               burst_d = BW'(1);
      else if (burst_q != BW'(MAX_BURST)) burst_d = burst_q + BW'(1);
    end else if (gnt[1] && lock[1]) begin
      state_d = OWN_B;
      if (state_q != OWN_B)               burst_d = BW'(1);
      else if (burst_q != BW'(MAX_BURST)) burst_d = burst_q + BW'(1);
    end else begin
      state_d = IDLE;
      burst_d = '0;
    end

    if (gnt[0])      last_b_d = 1'b0;
    else if (gnt[1]) last_b_d = 1'b1;

    if (req[1] && !gnt[1])
      starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
    else
      starve_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      burst_q  <= '0;
      starve_q <= '0;
      last_b_q <= 1'b1;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      starve_q <= starve_d;
      last_b_q <= last_b_d;
      for (int p = 0; p < 2; p++) begin
        rvalid_q[p] <= gnt[p] & ~we[p];
        if (gnt[p] && !we[p]) rdata_q[p] <= bus.ram_data_out;
      end
    end
  end

  assign bus.a_gnt       = gnt[0];
  assign bus.b_gnt       = gnt[1];
  // a read return landing in a reset cycle is dropped
  assign bus.a_rvalid    = rvalid_q[0] & ~rst_i;
  assign bus.b_rvalid    = rvalid_q[1] & ~rst_i;
  assign bus.a_rdata     = rdata_q[0];
  assign bus.b_rdata     = rdata_q[1];
  assign bus.ram_load    = |(gnt & we);
  assign bus.ram_address = gnt[0] ? addr[0]  : (gnt[1] ? addr[1]  : 12'h000);
  assign bus.ram_data_in = gnt[0] ? wdata[0] : (gnt[1] ? wdata[1] : 16'h0000);
endmodule
